// File: rtl/cprv_ram_1p.sv
// cprv_ram_1p_ctrl: valid/ready requester front-end for the cprv_ram_1p single-port RAM.
// Optional zero-fill of the whole RAM after reset is enabled with `define CPRV_RAM_INIT_EN.
module cprv_ram_1p_ctrl #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_we,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  ram_w_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);
    logic                  run;
    logic                  init_we;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic                  accept;
    logic                  pend;
    logic                  pend_we;
    logic                  push;
    logic                  pop;
    logic [1:0]            count;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [DATA_WIDTH:0]   fifo [3];

`ifdef CPRV_RAM_INIT_EN
    typedef enum logic {INIT, RUN} state_t;
    state_t                state;
    logic [ADDR_WIDTH-1:0] init_cnt;

    // Zero-fill sweep: one RAM word per cycle, then hand over to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else if (state == INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (&init_cnt) state <= RUN;
        end
    end

    assign run       = (state == RUN);
    assign init_we   = (state == INIT);
    assign init_addr = init_cnt;
`else
    assign run       = 1'b1;
    assign init_we   = 1'b0;
    assign init_addr = '0;
`endif

    // All outputs read as idle while reset is held, whatever the registered state.
    assign init_done = !rst && run;
    assign req_ready = init_done && (({1'b0, count} + {2'b0, pend}) < 3'd3);
    assign accept    = req_valid && req_ready;
    assign ram_w_en  = !rst && (init_we || (accept && req_we));
    assign ram_addr  = rst ? '0 : (run ? req_addr : init_addr);
    assign ram_wdata = init_done ? req_wdata : '0;

    assign push      = pend;
    assign rsp_valid = !rst && (count != 2'd0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_we    = rst ? 1'b0 : fifo[rd_ptr][DATA_WIDTH];
    assign rsp_rdata = rst ? '0 : fifo[rd_ptr][DATA_WIDTH-1:0];

    // One-cycle marker covering the RAM read latency of the accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend    <= 1'b0;
            pend_we <= 1'b0;
        end else begin
            pend <= accept;
            if (accept) pend_we <= req_we;
        end
    end

    // Three-entry in-order response FIFO; the ready rule keeps it from overflowing.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            for (int i = 0; i < 3; i++) fifo[i] <= '0;
        end else begin
            assert (!(push && !pop && count == 2'd3));
            if (push) begin
                fifo[wr_ptr] <= {pend_we, ram_rdata};
                wr_ptr       <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule
